// File: rtl/demod_ch_scheduler.sv
// Round-robin scheduler sharing one FM angle-difference datapath across NUM_CH AXI-stream channels.
// Define DEMOD_SCHED_BURST_EN to hold a grant for up to MAX_BURST beats; otherwise grants are per beat.
module demod_ch_scheduler #(
   parameter int NUM_CH    = 4,
   parameter int CH_W      = $clog2(NUM_CH),
   parameter int MAX_BURST = 16
) (
   input  logic                 s00_axis_aclk,
   input  logic                 s00_axis_aresetn,
   input  logic [NUM_CH-1:0]    s00_axis_tvalid,
   input  logic [NUM_CH*32-1:0] s00_axis_tdata,
   input  logic [NUM_CH-1:0]    s00_axis_tlast,
   output logic [NUM_CH-1:0]    s00_axis_tready,
   input  logic [NUM_CH-1:0]    ctx_clear,
   input  logic                 m00_axis_tready,
   output logic                 m00_axis_tvalid,
   output logic [31:0]          m00_axis_tdata,
   output logic                 m00_axis_tlast,
   output logic [3:0]           m00_axis_tstrb,
   output logic [CH_W-1:0]      m00_axis_tuser
);

   typedef enum logic [0:0] {IDLE, GRANT} state_t;

   // The reset port is active-high despite its "n" suffix.
   logic rst;
   assign rst = s00_axis_aresetn;

   state_t            state, state_nxt;
   logic [CH_W-1:0]   gnt, last, sel;
   logic [NUM_CH-1:0] primed, gnt_mask;
   logic [15:0]       prev [NUM_CH];
   logic [15:0]       angle [NUM_CH];
   logic [NUM_CH*16-1:0] lo_bits;
   logic [15:0]       gnt_angle, diff_q;
   logic              gnt_valid, others_valid, accept, burst_done, release_gnt;
   logic              unused_sink;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_unpack
      assign angle[k]            = s00_axis_tdata[32*k+16 +: 16];
      assign lo_bits[16*k +: 16] = s00_axis_tdata[32*k +: 16];
   end
   assign unused_sink = ^{lo_bits, (MAX_BURST > 0)};

   assign gnt_mask     = NUM_CH'(1) << gnt;
   assign gnt_angle    = angle[gnt];
   assign gnt_valid    = s00_axis_tvalid[gnt];
   assign others_valid = |(s00_axis_tvalid & ~gnt_mask);
   assign accept       = gnt_valid & s00_axis_tready[gnt];

   // Descending scan: the last hit is the nearest valid channel after `last`.
   always_comb begin
      sel = last;
      for (int i = NUM_CH; i >= 1; i--) begin
         if (s00_axis_tvalid[CH_W'((int'(last) + i) % NUM_CH)])
            sel = CH_W'((int'(last) + i) % NUM_CH);
      end
   end

`ifdef DEMOD_SCHED_BURST_EN
   localparam int BCNT_W = $clog2(MAX_BURST + 1);
   logic [BCNT_W-1:0] beat_cnt;

   assign burst_done = (beat_cnt == BCNT_W'(MAX_BURST - 1));

   always_ff @(posedge s00_axis_aclk) begin
      if (rst)
         beat_cnt <= '0;
      else if (state == IDLE)
         beat_cnt <= '0;
      else if (accept)
         beat_cnt <= beat_cnt + BCNT_W'(1);
   end
`else
   assign burst_done = 1'b1;
`endif

   assign release_gnt = (accept & (s00_axis_tlast[gnt] | burst_done))
                      | (~gnt_valid & others_valid);

   // NOTE: non-blocking assignments so every flop samples pre-edge values whatever the block order.
   always_ff @(posedge s00_axis_aclk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // NOTE: default first so every path assigns state_nxt and no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (|s00_axis_tvalid) state_nxt = GRANT;
         GRANT:   if (release_gnt)      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      s00_axis_tready = '0;
      if (state == GRANT && !rst)
         s00_axis_tready[gnt] = m00_axis_tready | ~m00_axis_tvalid;
      m00_axis_tdata = {16'h0000, diff_q};
      m00_axis_tstrb = m00_axis_tvalid ? 4'hF : 4'h0;
   end

   always_ff @(posedge s00_axis_aclk) begin
      if (rst) begin
         gnt             <= '0;
         last            <= CH_W'(NUM_CH - 1);
         primed          <= '0;
         // NOTE: prev is a small flop array, so it is cleared with the rest; primed alone already masks it.
         for (int k = 0; k < NUM_CH; k++) prev[k] <= '0;
         diff_q          <= '0;
         m00_axis_tvalid <= 1'b0;
         m00_axis_tlast  <= 1'b0;
         m00_axis_tuser  <= '0;
      end else begin
         if (state == IDLE && |s00_axis_tvalid) begin
            gnt  <= sel;
            last <= sel;
         end
         if (accept) begin
            prev[gnt]       <= gnt_angle;
            diff_q          <= primed[gnt] ? gnt_angle - prev[gnt] : 16'h0000;
            m00_axis_tlast  <= s00_axis_tlast[gnt];
            m00_axis_tuser  <= gnt;
            m00_axis_tvalid <= 1'b1;
         end else if (m00_axis_tvalid && m00_axis_tready) begin
            m00_axis_tvalid <= 1'b0;
         end
         // A same-cycle clear wins over the priming done by an accept.
         primed <= (primed | (accept ? gnt_mask : '0)) & ~ctx_clear;
      end
   end

endmodule

// File: tb/tb_demod_ch_scheduler.sv
// Self-checking bench for demod_ch_scheduler: directed scenarios plus randomized traffic,
// checked against per-channel angle-difference reference queues.
module tb_demod_ch_scheduler;
   localparam int NCH = 4;
   localparam int MB  = 4;
`ifdef DEMOD_SCHED_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   typedef struct packed { logic [15:0] angle; logic last; } beat_t;
   typedef struct packed { logic [15:0] diff; logic last; } exp_t;
   typedef struct packed { logic [1:0] ch; logic [15:0] diff; logic last; } obs_t;

   logic             clk = 1'b0;
   logic             rst;
   logic [NCH-1:0]   tvalid, tlast, tready, ctx_clear;
   logic [NCH*32-1:0] tdata;
   logic             m_tready, m_tvalid, m_tlast;
   logic [31:0]      m_tdata;
   logic [3:0]       m_tstrb;
   logic [1:0]       m_tuser;

   always #5 clk = ~clk;

   demod_ch_scheduler #(.NUM_CH(NCH), .MAX_BURST(MB)) dut (
      .s00_axis_aclk   (clk),
      .s00_axis_aresetn(rst),
      .s00_axis_tvalid (tvalid),
      .s00_axis_tdata  (tdata),
      .s00_axis_tlast  (tlast),
      .s00_axis_tready (tready),
      .ctx_clear       (ctx_clear),
      .m00_axis_tready (m_tready),
      .m00_axis_tvalid (m_tvalid),
      .m00_axis_tdata  (m_tdata),
      .m00_axis_tlast  (m_tlast),
      .m00_axis_tstrb  (m_tstrb),
      .m00_axis_tuser  (m_tuser)
   );

   beat_t       src_q [NCH][$];
   exp_t        exp_q [NCH][$];
   obs_t        obs_q [$];
   logic [15:0] mdl_prev [NCH];
   bit          mdl_primed [NCH];
   int          valid_pct = 100, ready_pct = 100, clr_pct = 0, stall = 0;
   logic [NCH-1:0] pend_clr = '0;
   bit          held = 1'b0;
   logic [31:0] held_data;
   logic        held_last;
   logic [1:0]  held_user;
   int          errors = 0, checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int c, input logic [15:0] a, input logic l);
      beat_t b;
      b.angle = a;
      b.last  = l;
      src_q[c].push_back(b);
   endtask

   function automatic bit idle_all();
      bit r = (tvalid == '0) && !m_tvalid;
      for (int c = 0; c < NCH; c++)
         if (src_q[c].size() != 0 || exp_q[c].size() != 0) r = 1'b0;
      return r;
   endfunction

   // One clock: observe and score at the negedge, then drive new inputs just after the posedge.
   task automatic cycle();
      logic [NCH-1:0] hs_v;
      beat_t b;
      exp_t  e;
      obs_t  o;
      @(negedge clk);
      hs_v = '0;
      if (rst) begin
         for (int c = 0; c < NCH; c++) begin
            exp_q[c].delete();
            mdl_prev[c]   = 16'h0;
            mdl_primed[c] = 1'b0;
         end
         held = 1'b0;
      end else begin
         check("tready_onehot0", 32'($onehot0(tready)), 1);
         if (held) begin
            check("hold_valid", m_tvalid, 1);
            check("hold_data", m_tdata, held_data);
            check("hold_user", m_tuser, held_user);
            check("hold_last", m_tlast, held_last);
         end
         if (m_tvalid && !m_tready) check("bp_tready", tready, 0);
         held      = m_tvalid && !m_tready;
         held_data = m_tdata;
         held_user = m_tuser;
         held_last = m_tlast;
         if (m_tvalid && m_tready) begin
            check("beat_expected", exp_q[m_tuser].size() > 0, 1);
            if (exp_q[m_tuser].size() > 0) begin
               e = exp_q[m_tuser].pop_front();
               check("out_data", m_tdata, {16'h0, e.diff});
               check("out_last", m_tlast, e.last);
               check("out_strb", m_tstrb, 4'hF);
            end
            o.ch = m_tuser; o.diff = m_tdata[15:0]; o.last = m_tlast;
            obs_q.push_back(o);
         end
         for (int c = 0; c < NCH; c++) begin
            if (tvalid[c] && tready[c] && src_q[c].size() > 0) begin
               b      = src_q[c].pop_front();
               e.diff = mdl_primed[c] ? b.angle - mdl_prev[c] : 16'h0;
               e.last = b.last;
               exp_q[c].push_back(e);
               mdl_prev[c]   = b.angle;
               mdl_primed[c] = 1'b1;
               hs_v[c]       = 1'b1;
            end
         end
         for (int c = 0; c < NCH; c++)
            if (ctx_clear[c]) mdl_primed[c] = 1'b0;
      end
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
         if (!(tvalid[c] && !hs_v[c])) begin
            if (src_q[c].size() > 0 && $urandom_range(99) < valid_pct) begin
               tvalid[c]          = 1'b1;
               tdata[32*c +: 32]  = {src_q[c][0].angle, 16'($urandom)};
               tlast[c]           = src_q[c][0].last;
            end else begin
               tvalid[c] = 1'b0;
               tlast[c]  = 1'b0;
            end
         end
      end
      if (stall > 0) begin
         m_tready = 1'b0;
         stall--;
      end else begin
         m_tready = ($urandom_range(99) < ready_pct);
      end
      if (clr_pct > 0) begin
         for (int c = 0; c < NCH; c++) ctx_clear[c] = ($urandom_range(99) < clr_pct);
      end else begin
         ctx_clear = pend_clr;
         pend_clr  = '0;
      end
   endtask

   task automatic drain(input string tag, input int max_cyc);
      int n = 0;
      while (!idle_all() && n < max_cyc) begin
         cycle();
         n++;
      end
      check({tag, "_drained"}, idle_all(), 1);
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      tvalid = '0;
      tlast  = '0;
      for (int c = 0; c < NCH; c++) src_q[c].delete();
      cycle();
      check("rst_m_tvalid", m_tvalid, 0);
      check("rst_s_tready", tready, 0);
      check("rst_m_tdata", m_tdata, 0);
      check("rst_m_tuser", m_tuser, 0);
      check("rst_m_tlast", m_tlast, 0);
      check("rst_m_tstrb", m_tstrb, 0);
      rst = 1'b0;
      obs_q.delete();
   endtask

   task automatic check_obs(input string tag, input int idx, input logic [1:0] ch, input logic [15:0] d);
      obs_t o;
      if (idx < obs_q.size()) o = obs_q[idx];
      else o = 'x;
      check({tag, "_ch"}, o.ch, ch);
      check({tag, "_diff"}, o.diff, d);
   endtask

   initial begin
      int k;
      rst = 1'b1; tvalid = '0; tdata = '0; tlast = '0; ctx_clear = '0; m_tready = 1'b1;

      // First beat of a channel is unprimed, second is a plain difference.
      do_reset();
      push(0, 16'h1000, 1'b0);
      push(0, 16'h1400, 1'b0);
      drain("t1", 200);
      check("t1_count", obs_q.size(), 2);
      check_obs("t1_b0", 0, 2'd0, 16'h0000);
      check_obs("t1_b1", 1, 2'd0, 16'h0400);

      // Modular wrap in both directions.
      do_reset();
      push(1, 16'hFFF0, 1'b0);
      push(1, 16'h0010, 1'b0);
      drain("t2a", 200);
      check_obs("t2a_b0", 0, 2'd1, 16'h0000);
      check_obs("t2a_b1", 1, 2'd1, 16'h0020);
      do_reset();
      push(1, 16'h0010, 1'b0);
      push(1, 16'hFFF0, 1'b0);
      drain("t2b", 200);
      check_obs("t2b_b1", 1, 2'd1, 16'hFFE0);

      // Round robin with every channel continuously valid.
      do_reset();
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < 8; i++) push(c, 16'($urandom), 1'b0);
      drain("t3", 400);
      check("t3_count", obs_q.size(), 32);
      for (int i = 0; i < 32; i++)
         check("t3_tuser", (i < obs_q.size()) ? obs_q[i].ch : 2'bxx,
               BURST ? (i / MB) % NCH : i % NCH);

      // Output backpressure mid-stream.
      do_reset();
      for (int i = 0; i < 6; i++) begin
         push(0, 16'($urandom), 1'b0);
         push(1, 16'($urandom), 1'b0);
      end
      repeat (4) cycle();
      stall = 5;
      repeat (3) cycle();
      check("t4_stall_valid", m_tvalid, 1);
      check("t4_stall_tready", tready, 0);
      drain("t4", 400);
      check("t4_count", obs_q.size(), 12);

      // tlast on ch2's third beat ends its grant; ch3 follows.
      do_reset();
      for (int i = 0; i < 5; i++) push(2, 16'($urandom), i == 2);
      for (int i = 0; i < 4; i++) push(3, 16'($urandom), 1'b0);
      drain("t5", 400);
      check("t5_count", obs_q.size(), 9);
      k = BURST ? 2 : 4;
      check("t5_last_ch", (k < obs_q.size()) ? obs_q[k].ch : 2'bxx, 2);
      check("t5_last_flag", (k < obs_q.size()) ? obs_q[k].last : 1'bx, 1);
      check("t5_next_ch", (k + 1 < obs_q.size()) ? obs_q[k+1].ch : 2'bxx, 3);

      // Context clear between beats un-primes the channel.
      do_reset();
      push(0, 16'h2000, 1'b0);
      drain("t6a", 200);
      pend_clr = 4'b0001;
      cycle();
      cycle();
      push(0, 16'h2100, 1'b0);
      push(0, 16'h2300, 1'b0);
      drain("t6b", 200);
      check("t6_count", obs_q.size(), 3);
      check_obs("t6_b0", 0, 2'd0, 16'h0000);
      check_obs("t6_b1", 1, 2'd0, 16'h0000);
      check_obs("t6_b2", 2, 2'd0, 16'h0200);

      // Reset in the middle of a ch0 stream: outputs clear and ch0 is granted first.
      do_reset();
      for (int i = 0; i < 8; i++) push(0, 16'($urandom), 1'b0);
      repeat (4) cycle();
      for (int i = 0; i < 4; i++) push(1, 16'($urandom), 1'b0);
      rst = 1'b1;
      cycle();
      check("t7_m_tvalid", m_tvalid, 0);
      check("t7_s_tready", tready, 0);
      check("t7_m_tdata", m_tdata, 0);
      check("t7_m_tuser", m_tuser, 0);
      rst = 1'b0;
      obs_q.delete();
      drain("t7", 400);
      check_obs("t7_first", 0, 2'd0, 16'h0000);

      // Randomized traffic, throttling, backpressure and context clears.
      do_reset();
      valid_pct = 70; ready_pct = 60; clr_pct = 3;
      for (int c = 0; c < NCH; c++)
         for (int i = 0; i < 60; i++) push(c, 16'($urandom), ($urandom_range(7) == 0));
      drain("t8", 6000);
      check("t8_count", obs_q.size(), 240);
      valid_pct = 100; ready_pct = 100; clr_pct = 0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/demod_ch_scheduler.md
# demod_ch_scheduler

Time-shares one FM angle-difference (discriminator) datapath among `NUM_CH` tuner channels. The block round-robin arbitrates the per-channel AXI-stream angle inputs and keeps each channel's previous-angle context. It emits one merged, channel-tagged output stream of 16-bit phase differences to the audio/decimation chain. It replaces one single-channel demodulator instance per channel.

## Interface
- `NUM_CH`, 4: number of channel input streams (2..8).
- `CH_W`, `$clog2(NUM_CH)`: channel-id width.
- `MAX_BURST`, 16: maximum beats per grant when bursting is compiled in.

Ports:
- `s00_axis_aclk`  in  1  clock.
- `s00_axis_aresetn`  in  1  reset, synchronous, active-high (asserted = 1, despite the suffix).
- `s00_axis_tvalid`  in  NUM_CH  per-channel valid.
- `s00_axis_tdata`  in  NUM_CH*32  per-channel beat; channel k in `[32k+31:32k]`, angle in `[31:16]` of each slice, `[15:0]` ignored.
- `s00_axis_tlast`  in  NUM_CH  per-channel frame end.
- `s00_axis_tready`  out  NUM_CH  per-channel ready; at most one bit high.
- `ctx_clear`  in  NUM_CH  per-channel context clear (un-prime).
- `m00_axis_tready`  in  1  downstream ready.
- `m00_axis_tvalid`  out  1  output valid.
- `m00_axis_tdata`  out  32  `{16'b0, diff[15:0]}`.
- `m00_axis_tlast`  out  1  copy of accepted input tlast.
- `m00_axis_tstrb`  out  4  constant `4'hF` when valid, else 0.
- `m00_axis_tuser`  out  CH_W  channel id of the output beat.

## Operation
- FSM states: `IDLE`, `GRANT`.
- `IDLE`: when any `s00_axis_tvalid` is high, select the first valid channel searching from `last+1` modulo `NUM_CH`. Record it as `gnt` and `last`, clear `beat_cnt`, go to `GRANT`. No beat is accepted in the selection cycle.
- `GRANT`: `s00_axis_tready[gnt] = m00_axis_tready | ~m00_axis_tvalid`. All other ready bits are 0.
- Accept = `tvalid[gnt] & tready[gnt]`.
- On accept:
  - `diff = angle - prev[gnt]`, 16-bit modular (wrap-around) subtraction.
  - If `primed[gnt]=0`, diff is forced to 0.
  - Then `prev[gnt] <= angle` and `primed[gnt] <= 1`.
  - Output register loads `diff`, `gnt`, tlast; `m00_axis_tvalid <= 1`.
- Without accept: `m00_axis_tvalid` clears when `m00_axis_tvalid & m00_axis_tready`.
- Grant release (to `IDLE`), evaluated each `GRANT` cycle:
  - Accepted beat with tlast = 1.
  - `beat_cnt` reaching `MAX_BURST` on an accept (burst build only).
  - After every accept (non-burst build).
  - `tvalid[gnt]=0` while any other channel's tvalid = 1.
- `ctx_clear[k]` sets `primed[k] <= 0`. It has priority over a same-cycle accept on k; that beat still outputs its computed diff.
- Reset values:
  - FSM `IDLE`; `last = NUM_CH-1`, so ch0 wins first.
  - All `primed = 0`; `prev` = 0.
  - All outputs 0, including `s00_axis_tready` and `m00_axis_tvalid`.

## Timing
- Latency: accepted input beat appears on `m00_axis_t*` the next cycle.
- Throughput: 1 beat/cycle within a grant.
- One idle selection cycle per grant change.
- Backpressure: with `m00_axis_tvalid=1` and `m00_axis_tready=0`, `tready[gnt]=0` and the output holds stable. No data is dropped or duplicated.
- Reset mid-burst: the next cycle is in reset state and any pending output beat is discarded. Upstream must treat the in-flight beat as lost.
- All channels idle: stay in `IDLE`, `m00_axis_tvalid` drains normally.

## Configuration
- `DEMOD_SCHED_BURST_EN` defined:
  - A grant holds until tlast, `MAX_BURST` accepted beats, or the stall-release rule.
  - `beat_cnt` is `$clog2(MAX_BURST+1)` bits.
- Not defined:
  - The grant releases after every accepted beat (per-beat round robin).
  - `beat_cnt` and `MAX_BURST` are unused.
  - Throughput is at most 1 beat per 2 cycles.

## Test plan
- Reset, then ch0 sends angles 0x1000, 0x1400 → outputs diff 0x0000 (unprimed), 0x0400, tuser = 0.
- Wrap: ch1 sends 0xFFF0 then 0x0010 → second output diff 0x0020; ch1 sends 0x0010 then 0xFFF0 → 0xFFE0.
- All 4 channels continuously valid, no tlast, burst build, MAX_BURST = 4 → tuser sequence 0,0,0,0,1,1,1,1,2,… Non-burst build → 0,1,2,3,0,… Per-channel diffs stay independent.
- Hold `m00_axis_tready=0` for 5 cycles mid-burst → output stable, `tready[gnt]=0`. On release, no lost or duplicated beats; the scoreboard matches.
- tlast on ch2's third beat → `m00_axis_tlast=1` on that output, next grant goes to ch3.
- `ctx_clear[0]` pulsed between ch0 beats 0x2000 and 0x2100 → second output is 0x0000, third beat 0x2300 → 0x0200. Reset asserted mid-burst → all outputs 0 next cycle, ch0 granted first.
